ws2811_stream_encoder: RTL and testbench

Parametrised successor to the fixed 4-subcell WS2811 serializer. It takes a byte stream on a valid/ready handshake, typically from the read side of the USB-receive FIFO. It emits a gap-free WS2811 bit waveform with parametrised bit and high-time lengths, frame length and byte order. Each frame ends with a guaranteed latch gap, and a mid-frame underrun is detected and recovered without corrupting the next frame.

---
 rtl/ws2811_pkg.sv | 24 ++
 rtl/ws2811_bit_cell.sv | 52 +++++
 rtl/ws2811_stream_encoder.sv | 165 ++++++++++++++++
 tb/tb_ws2811_stream_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// Shared definitions for the WS2811 stream encoder.
// Holds the FSM encoding, a counter-width helper and 12.8 MHz timing defaults.
package ws2811_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCell  = 2'd1,
    StLatch = 2'd2
  } state_e;

  localparam int unsigned DefTbitCyc  = 16;
  localparam int unsigned DefT0hCyc   = 4;
  localparam int unsigned DefT1hCyc   = 12;
  localparam int unsigned DefResetCyc = 640;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ws2811_bit_cell.sv
// One WS2811 bit cell: cycle counter plus high/low compare.
// The output is registered from next-cycle inputs so the pin tracks the cell counter directly.
module ws2811_bit_cell
  import ws2811_pkg::*;
#(
  parameter int unsigned TBIT_CYC = DefTbitCyc,
  parameter int unsigned T0H_CYC  = DefT0hCyc,
  parameter int unsigned T1H_CYC  = DefT1hCyc
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_active_next,
  input  logic i_bit_next,
  output logic o_ws2811,
  output logic o_cell_last
);

  localparam int unsigned CW = cnt_width(TBIT_CYC);
  localparam logic [CW-1:0] LastCnt = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] T0hCnt  = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1hCnt  = CW'(T1H_CYC);

  logic [CW-1:0] r_cellcnt;
  logic [CW-1:0] w_cellcnt_d;
  logic          r_ws2811;
  logic          w_ws2811_d;
  logic          w_last;

  always_comb begin
    w_last      = i_active && (r_cellcnt == LastCnt);
    w_cellcnt_d = '0;
    if (i_active && !w_last) begin
      w_cellcnt_d = r_cellcnt + CW'(1);
    end
    w_ws2811_d = i_active_next && (w_cellcnt_d < (i_bit_next ? T1hCnt : T0hCnt));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cellcnt <= '0;
      r_ws2811  <= 1'b0;
    end else begin
      r_cellcnt <= w_cellcnt_d;
      r_ws2811  <= w_ws2811_d;
    end
  end

  assign o_ws2811    = r_ws2811;
  assign o_cell_last = w_last;

endmodule

// File: rtl/ws2811_stream_encoder.sv
// WS2811 stream encoder: valid/ready byte input, gap-free bit cells, latch gap after each frame
// and underrun recovery that abandons the partial frame.
module ws2811_stream_encoder
  import ws2811_pkg::*;
#(
  parameter int unsigned TBIT_CYC      = DefTbitCyc,
  parameter int unsigned T0H_CYC       = DefT0hCyc,
  parameter int unsigned T1H_CYC       = DefT1hCyc,
  parameter int unsigned RESET_CYC     = DefResetCyc,
  parameter int unsigned NUM_LEDS      = 60,
  parameter int unsigned BYTES_PER_LED = 3,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic       o_ws2811,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_frame_err
);

  localparam int unsigned FrameBytes = NUM_LEDS * BYTES_PER_LED;
  localparam int unsigned BW = cnt_width(FrameBytes);
  localparam int unsigned GW = cnt_width(RESET_CYC);
  localparam logic [BW-1:0] LastByte = BW'(FrameBytes - 1);
  localparam logic [GW-1:0] LastGap  = GW'(RESET_CYC - 1);

  state_e        r_state, w_state_d;
  logic [7:0]    r_hold, w_hold_d;
  logic          r_hold_valid, w_hold_valid_d;
  logic [7:0]    r_shift, w_shift_d;
  logic [2:0]    r_bitcnt, w_bitcnt_d;
  logic [BW-1:0] r_bytecnt, w_bytecnt_d;
  logic [GW-1:0] r_gapcnt, w_gapcnt_d;
  logic          r_frame_ok, w_frame_ok_d;

  logic w_take;
  logic w_load;
  logic w_cell_last;
  logic w_byte_last;
  logic w_in_cell;
  logic w_in_cell_next;
  logic w_bit_next;

  assign o_s_ready      = ~r_hold_valid;
  assign o_busy         = (r_state != StIdle);
  assign w_take         = i_s_valid & o_s_ready;
  assign w_in_cell      = (r_state == StCell);
  assign w_in_cell_next = (w_state_d == StCell);

  always_comb begin
    w_state_d      = r_state;
    w_hold_d       = r_hold;
    w_hold_valid_d = r_hold_valid;
    w_shift_d      = r_shift;
    w_bitcnt_d     = r_bitcnt;
    w_bytecnt_d    = r_bytecnt;
    w_gapcnt_d     = r_gapcnt;
    w_frame_ok_d   = r_frame_ok;
    w_load         = 1'b0;
    o_frame_done   = 1'b0;
    o_frame_err    = 1'b0;
    w_byte_last    = w_cell_last && (r_bitcnt == 3'd7);

    unique case (r_state)
      StIdle: begin
        if (r_hold_valid) begin
          w_load      = 1'b1;
          w_bytecnt_d = '0;
          w_bitcnt_d  = '0;
          w_state_d   = StCell;
        end
      end
      StCell: begin
        if (w_cell_last) begin
          w_bitcnt_d = r_bitcnt + 3'd1;
        end
        if (w_byte_last) begin
          if (r_bytecnt == LastByte) begin
            w_state_d    = StLatch;
            w_gapcnt_d   = '0;
            w_bytecnt_d  = '0;
            w_frame_ok_d = 1'b1;
          end else if (r_hold_valid) begin
            // Reload straight from hold so the next byte's first cell follows with no gap.
            w_load      = 1'b1;
            w_bytecnt_d = r_bytecnt + BW'(1);
          end else begin
            o_frame_err  = 1'b1;
            w_state_d    = StLatch;
            w_gapcnt_d   = '0;
            w_bytecnt_d  = '0;
            w_frame_ok_d = 1'b0;
          end
        end
      end
      StLatch: begin
        if (r_gapcnt == LastGap) begin
          o_frame_done = r_frame_ok;
          w_frame_ok_d = 1'b0;
          w_gapcnt_d   = '0;
          w_state_d    = StIdle;
        end else begin
          w_gapcnt_d = r_gapcnt + GW'(1);
        end
      end
      default: begin
        w_state_d = StLatch;
        w_gapcnt_d = '0;
      end
    endcase

    if (w_load) begin
      w_shift_d      = r_hold;
      w_hold_valid_d = 1'b0;
    end else if (w_take) begin
      w_hold_valid_d = 1'b1;
    end
    if (w_take) begin
      w_hold_d = i_s_data;
    end

    w_bit_next = MSB_FIRST ? w_shift_d[3'd7 - w_bitcnt_d] : w_shift_d[w_bitcnt_d];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StLatch;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_bytecnt    <= '0;
      r_gapcnt     <= '0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_hold       <= w_hold_d;
      r_hold_valid <= w_hold_valid_d;
      r_shift      <= w_shift_d;
      r_bitcnt     <= w_bitcnt_d;
      r_bytecnt    <= w_bytecnt_d;
      r_gapcnt     <= w_gapcnt_d;
      r_frame_ok   <= w_frame_ok_d;
    end
  end

  ws2811_bit_cell #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_bit_cell (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_active      (w_in_cell),
    .i_active_next (w_in_cell_next),
    .i_bit_next    (w_bit_next),
    .o_ws2811      (o_ws2811),
    .o_cell_last   (w_cell_last)
  );

endmodule

// File: tb/tb_ws2811_stream_encoder.sv
// Bench for ws2811_stream_encoder: three instances (1-byte MSB, 1-byte LSB, 2-LED RGB) driven by
// a vector table plus hand-written back-to-back, underrun and async-reset sequences.
module tb_ws2811_stream_encoder;

  localparam int ResetCyc = 640;

  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  data;
    logic [31:0] hi;    // expected high cycles per cell, cell 0 in the top nibble
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_n;
  logic [2:0]      s_valid;
  logic [2:0][7:0] s_data;
  logic [2:0]      s_ready;
  logic [2:0]      ws;
  logic [2:0]      busy;
  logic [2:0]      done;
  logic [2:0]      err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] feed_bytes [8];
  int         exp_hi [64];
  int         wait_cyc, err_cnt, err_pos, done_in, ready_low;
  vec_t       vecs [6];

  ws2811_stream_encoder #(
    .TBIT_CYC(16), .T0H_CYC(4), .T1H_CYC(12), .RESET_CYC(640),
    .NUM_LEDS(1), .BYTES_PER_LED(1), .MSB_FIRST(1'b1)
  ) u_msb (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_s_data(s_data[0]), .i_s_valid(s_valid[0]),
    .o_s_ready(s_ready[0]), .o_ws2811(ws[0]), .o_busy(busy[0]),
    .o_frame_done(done[0]), .o_frame_err(err[0])
  );

  ws2811_stream_encoder #(
    .TBIT_CYC(16), .T0H_CYC(4), .T1H_CYC(12), .RESET_CYC(640),
    .NUM_LEDS(1), .BYTES_PER_LED(1), .MSB_FIRST(1'b0)
  ) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_s_data(s_data[1]), .i_s_valid(s_valid[1]),
    .o_s_ready(s_ready[1]), .o_ws2811(ws[1]), .o_busy(busy[1]),
    .o_frame_done(done[1]), .o_frame_err(err[1])
  );

  ws2811_stream_encoder #(
    .TBIT_CYC(16), .T0H_CYC(4), .T1H_CYC(12), .RESET_CYC(640),
    .NUM_LEDS(2), .BYTES_PER_LED(3), .MSB_FIRST(1'b1)
  ) u_rgb (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_s_data(s_data[2]), .i_s_valid(s_valid[2]),
    .o_s_ready(s_ready[2]), .o_ws2811(ws[2]), .o_busy(busy[2]),
    .o_frame_done(done[2]), .o_frame_err(err[2])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected high time per cell for an MSB-first byte stream.
  task automatic fill_exp(input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        exp_hi[b*8+i] = feed_bytes[b][7-i] ? 12 : 4;
      end
    end
  endtask

  // Offer feed_bytes[0..n-1] with s_valid held high; call on a falling edge.
  task automatic feed(input int idx, input int n);
    int   guard;
    logic acc;
    ready_low = 0;
    for (int k = 0; k < n; k++) begin
      s_valid[idx] = 1'b1;
      s_data[idx]  = feed_bytes[k];
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 3000) begin
        acc = s_ready[idx];
        if (!acc) ready_low++;
        @(negedge clk);
        guard++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL feed_timeout: byte %0d not accepted after %0d cycles", k, guard);
        break;
      end
    end
    s_valid[idx] = 1'b0;
  endtask

  // Wait for the first rising edge, then measure ncells contiguous 16-cycle cells.
  task automatic check_cells(input int idx, input int ncells, input string tag);
    int   hi;
    logic shape;
    wait_cyc = 0;
    while (!ws[idx] && wait_cyc < 3000) begin
      @(negedge clk);
      wait_cyc++;
    end
    err_cnt = 0;
    err_pos = -1;
    done_in = 0;
    if (!ws[idx]) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_start: ws never rose, waited %0d cycles", tag, wait_cyc);
      return;
    end
    for (int c = 0; c < ncells; c++) begin
      hi    = 0;
      shape = 1'b1;
      for (int j = 0; j < 16; j++) begin
        if (ws[idx]) begin
          if (hi != j) shape = 1'b0;
          hi++;
        end
        if (err[idx]) begin
          err_cnt++;
          err_pos = c * 16 + j;
        end
        if (done[idx]) done_in++;
        @(negedge clk);
      end
      check($sformatf("%s_cell%0d_high", tag, c), hi, exp_hi[c]);
      check($sformatf("%s_cell%0d_shape", tag, c), int'(shape), 1);
    end
  endtask

  // Latch gap starting on the first cycle after the last cell.
  task automatic check_gap(input int idx, input bit exp_done, input string tag);
    int lows, busy_lo, dcnt, dpos, ecnt;
    lows = 0; busy_lo = 0; dcnt = 0; dpos = -1; ecnt = 0;
    for (int g = 0; g < ResetCyc; g++) begin
      if (!ws[idx]) lows++;
      if (!busy[idx]) busy_lo++;
      if (done[idx]) begin
        dcnt++;
        dpos = g;
      end
      if (err[idx]) ecnt++;
      @(negedge clk);
    end
    check({tag, "_gap_low"}, lows, ResetCyc);
    check({tag, "_gap_busy_low"}, busy_lo, 0);
    check({tag, "_gap_err"}, ecnt, 0);
    if (exp_done) begin
      check({tag, "_done_cnt"}, dcnt, 1);
      check({tag, "_done_pos"}, dpos, ResetCyc - 1);
    end else begin
      check({tag, "_no_done"}, dcnt, 0);
    end
    check({tag, "_idle_busy"}, int'(busy[idx]), 0);
    check({tag, "_idle_done"}, int'(done[idx]), 0);
  endtask

  initial begin
    int cnt, lows, dn, k;
    rst_n   = '0;
    s_valid = '0;
    s_data  = '0;

    vecs[0] = '{inst: 2'd0, data: 8'hA5, hi: 32'hC4C4_4C4C};
    vecs[1] = '{inst: 2'd0, data: 8'h00, hi: 32'h4444_4444};
    vecs[2] = '{inst: 2'd0, data: 8'hFF, hi: 32'hCCCC_CCCC};
    vecs[3] = '{inst: 2'd0, data: 8'h0E, hi: 32'h4444_CCC4};
    vecs[4] = '{inst: 2'd1, data: 8'h01, hi: 32'hC444_4444};
    vecs[5] = '{inst: 2'd1, data: 8'h0E, hi: 32'h4CCC_4444};

    #12;
    check("rst_ws", int'(ws), 0);
    check("rst_busy", int'(busy), 7);
    check("rst_ready", int'(s_ready), 7);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    @(negedge clk);
    rst_n = '1;
    cnt = 0; lows = 0; dn = 0;
    while (busy[2] && cnt < 3000) begin
      if (!ws[2]) lows++;
      if (done[2]) dn++;
      @(negedge clk);
      cnt++;
    end
    check("rst_gap_len", cnt, ResetCyc);
    check("rst_gap_low", lows, ResetCyc);
    check("rst_gap_no_done", dn, 0);
    check("rst_idle_ready", int'(s_ready), 7);

    for (int v = 0; v < 6; v++) begin
      feed_bytes[0] = vecs[v].data;
      for (int c = 0; c < 8; c++) exp_hi[c] = int'(vecs[v].hi[(7-c)*4 +: 4]);
      feed(int'(vecs[v].inst), 1);
      check_cells(int'(vecs[v].inst), 8, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_err", v), err_cnt, 0);
      check($sformatf("vec%0d_done_early", v), done_in, 0);
      check_gap(int'(vecs[v].inst), 1'b1, $sformatf("vec%0d", v));
    end

    feed_bytes[0] = 8'h12; feed_bytes[1] = 8'h34; feed_bytes[2] = 8'h56;
    feed_bytes[3] = 8'h78; feed_bytes[4] = 8'h9A; feed_bytes[5] = 8'hBC;
    fill_exp(6);
    fork
      feed(2, 6);
      check_cells(2, 48, "b2b");
    join
    check("b2b_ready_low_seen", int'(ready_low > 0), 1);
    check("b2b_err", err_cnt, 0);
    check("b2b_done_early", done_in, 0);
    check_gap(2, 1'b1, "b2b");

    feed_bytes[0] = 8'hF0; feed_bytes[1] = 8'h3C;
    fill_exp(2);
    fork
      feed(2, 2);
      check_cells(2, 16, "urun");
    join
    check("urun_err_cnt", err_cnt, 1);
    check("urun_err_pos", err_pos, 255);
    check_gap(2, 1'b0, "urun");

    feed_bytes[0] = 8'h00; feed_bytes[1] = 8'hFF; feed_bytes[2] = 8'h81;
    feed_bytes[3] = 8'h7E; feed_bytes[4] = 8'hC3; feed_bytes[5] = 8'h5A;
    fill_exp(6);
    fork
      feed(2, 6);
      check_cells(2, 48, "recov");
    join
    check("recov_err", err_cnt, 0);
    check_gap(2, 1'b1, "recov");

    feed_bytes[0] = 8'hFF;
    feed(2, 1);
    k = 0;
    while (!ws[2] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("arst_pre_high", int'(ws[2]), 1);
    #2 rst_n[2] = 1'b0;
    #1;
    check("arst_ws", int'(ws[2]), 0);
    check("arst_busy", int'(busy[2]), 1);
    check("arst_ready", int'(s_ready[2]), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n[2]      = 1'b1;
    feed_bytes[0] = 8'h81;
    fill_exp(1);
    s_valid[2] = 1'b1;
    s_data[2]  = 8'h81;
    fork
      begin
        @(negedge clk);
        s_valid[2] = 1'b0;
      end
      check_cells(2, 8, "arst");
    join
    check("arst_gap_wait", wait_cyc, ResetCyc + 1);
    check("arst_err_cnt", err_cnt, 1);
    check("arst_err_pos", err_pos, 127);
    check("arst_done_early", done_in, 0);
    check_gap(2, 1'b0, "arst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "time limit");
  end

endmodule
